// File: rtl/clock_meter.sv
// clock_meter: reports period and high time of i_in, counted in i_clk cycles, once per input period.
// Optional build macro CLOCK_METER_SYNC_EN inserts a 2-flop synchronizer for an asynchronous i_in.
module clock_meter #(
   parameter int p_width = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_stop,
   input  logic               i_in,
   output logic [p_width-1:0] o_period,
   output logic [p_width-1:0] o_high,
   output logic               o_valid,
   output logic               o_lost
);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_MEASURE = 1'b1
   } state_t;

   localparam logic [p_width-1:0] LP_CNT_MAX = '1;
   localparam logic [p_width-1:0] LP_CNT_ONE = {{(p_width-1){1'b0}}, 1'b1};
   localparam logic [p_width-1:0] LP_CNT_ZERO = '0;

   state_t             r_state, w_state_nx;
   logic [p_width-1:0] r_cnt, w_cnt_nx;
   logic [p_width-1:0] r_high_q, w_high_q_nx;
   logic [p_width-1:0] r_period, w_period_nx;
   logic [p_width-1:0] r_high, w_high_nx;
   logic               r_valid, w_valid_nx;
   logic               r_lost, w_lost_nx;
   logic               r_prev;
   logic               w_s;
   logic               w_rise;
   logic               w_fall;

`ifdef CLOCK_METER_SYNC_EN
   logic r_sync1, r_sync2;

   // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true 2-stage chain.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = i_in;
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_prev <= 1'b0;
      else        r_prev <= w_s;
   end

   assign w_rise = w_s & ~r_prev;
   assign w_fall = ~w_s & r_prev;

   always_comb begin
      // NOTE: every target gets a default first, so no path leaves one unassigned and no latch is inferred.
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_high_q_nx = r_high_q;
      w_period_nx = r_period;
      w_high_nx   = r_high;
      w_valid_nx  = 1'b0;
      w_lost_nx   = r_lost;

      if (i_stop) begin
         w_state_nx  = S_IDLE;
         w_cnt_nx    = LP_CNT_ZERO;
         w_high_q_nx = LP_CNT_ZERO;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nx    = LP_CNT_ZERO;
               w_high_q_nx = LP_CNT_ZERO;
               if (w_rise) begin
                  w_cnt_nx   = LP_CNT_ONE;
                  w_state_nx = S_MEASURE;
               end
            end
            S_MEASURE: begin
               w_cnt_nx = r_cnt + LP_CNT_ONE;
               if (w_fall) w_high_q_nx = r_cnt;
               // A rise coinciding with saturation still closes a valid period.
               if (w_rise) begin
                  w_period_nx = r_cnt;
                  w_high_nx   = r_high_q;
                  w_valid_nx  = 1'b1;
                  w_lost_nx   = 1'b0;
                  w_cnt_nx    = LP_CNT_ONE;
               end else if (r_cnt == LP_CNT_MAX) begin
                  w_lost_nx   = 1'b1;
                  w_state_nx  = S_IDLE;
                  w_cnt_nx    = LP_CNT_ZERO;
                  w_high_q_nx = LP_CNT_ZERO;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= LP_CNT_ZERO;
         r_high_q <= LP_CNT_ZERO;
         r_period <= LP_CNT_ZERO;
         r_high   <= LP_CNT_ZERO;
         r_valid  <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_high_q <= w_high_q_nx;
         r_period <= w_period_nx;
         r_high   <= w_high_nx;
         r_valid  <= w_valid_nx;
         r_lost   <= w_lost_nx;
      end
   end

   assign o_period = r_period;
   assign o_high   = r_high;
   assign o_valid  = r_valid;
   assign o_lost   = r_lost;

endmodule

// File: doc/clock_meter.md
# clock_meter

Measures an incoming square wave (typically the `o_out` of a `clock` instance, or an external reference) against the system clock. It reports the period and high time of each full input cycle in system-clock cycles. It is the receiving counterpart of the clock generator, used for self-test of divider settings and for monitoring external clocks. Results are published once per input period with a one-cycle valid strobe, and loss of the input is flagged.

## Interface
- `p_width`, 16, width of the period and high-time counters and outputs.
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_stop`  in  1  synchronous freeze; while high, measurement is aborted and held off.
- `i_in`  in  1  measured signal; asynchronous to `i_clk` when the sync option is compiled in.
- `o_period`  out  `p_width`  system-clock cycles between consecutive rising edges of `i_in`.
- `o_high`  out  `p_width`  system-clock cycles `i_in` was high within that period.
- `o_valid`  out  1  one-cycle strobe; `o_period`/`o_high` updated this cycle.
- `o_lost`  out  1  sticky flag; no rising edge within 2^`p_width`−1 cycles.

## Operation
- **Front end:** optional 2-flop synchronizer (see Configuration), then a history register `s_prev`.
  - `rise = s & ~s_prev`.
  - `fall = ~s & s_prev`.
- **States:**
  - `IDLE`: waiting for the first rise.
  - `MEASURE`: timing a period.
- **IDLE:**
  - Counters are held at 0.
  - On `rise`: load `cnt <= 1`, go to MEASURE. No `o_valid`.
- **MEASURE:**
  - `cnt` increments each cycle.
  - On `fall`: capture `high_q <= cnt`.
  - On `rise`:
    - `o_period <= cnt`, `o_high <= high_q`, `o_valid <= 1`, `o_lost <= 0`.
    - Reload `cnt <= 1`, stay in MEASURE.
  - Result: for an input with period N and high time H (in clocks), `o_period = N` and `o_high = H`.
- **Saturation:**
  - If `cnt` reaches 2^`p_width`−1 without a rise: `o_lost <= 1`, go to IDLE.
  - `o_period`/`o_high` keep their last values. No `o_valid`.
- **Stop:** while `i_stop=1`:
  - State is forced to IDLE; `cnt` and `high_q` are cleared.
  - `o_valid=0`; `o_period`, `o_high` and `o_lost` hold.
  - After release, the first rise only restarts measurement; no valid is produced for it.
- **Simultaneous `rise` and saturation in the same cycle:** the rise wins. A valid result with `o_period` = 2^`p_width`−1 is reported; `o_lost` is not set.
- **Falls:** a fall in IDLE is ignored. Only the last fall before a rise determines `o_high`, which is always < `o_period`.
- **Reset (`i_rst=0`, asynchronous):**
  - State IDLE, synchronizer/history flops 0.
  - `o_period=0`, `o_high=0`, `o_valid=0`, `o_lost=0`.
  - Reset mid-period discards the partial measurement.

## Timing
- **Edge-detect latency** from an `i_in` transition to `rise`/`fall` asserted internally: 3 `i_clk` edges with sync, 1 without.
- `o_valid` and updated outputs appear on the clock edge following the rise cycle, for one cycle.
- `o_valid` is never high on two consecutive cycles.
- **Minimum measurable period:** 2 clocks (input toggling every cycle, synchronous to `i_clk`).
- **Asynchronous inputs:** edges are quantised to ±1 cycle.
- **Output retention:** all outputs are registered and hold between strobes.
- **`o_lost` timing:** asserts exactly 2^`p_width`−1 cycles after the last rise was detected.

## Configuration
- `CLOCK_METER_SYNC_EN` defined:
  - 2-flop synchronizer on `i_in`.
  - Edge-detect latency 3 cycles.
  - `i_in` may be fully asynchronous.
- Not defined:
  - `i_in` feeds `s` directly.
  - Latency 1 cycle.
  - `i_in` must be synchronous to `i_clk` (e.g. driven by `clock` on the same clock).
- Measured `o_period`/`o_high` values are identical in both builds for synchronous input.

## Test plan
- **Nominal:** synchronous input with period 10, high 3, macro on → first valid after the second rise with `o_period=10`, `o_high=3`, then `o_valid` every 10 cycles.
- **Minimum period:** input toggling every cycle (period 2, high 1) → `o_period=2`, `o_high=1`, `o_valid` every 2 cycles.
- **Loss:** `p_width=8`, input stuck low after a rise → `o_lost=1` exactly 255 cycles after the rise, no `o_valid`. Restore a period-20 input → `o_lost` clears with the first valid after two rises, `o_period=20`.
- **Stop:** assert `i_stop` for 5 cycles mid-period → no `o_valid` for that period, outputs hold. After release, the first valid occurs at the second rise post-release.
- **Reset:** assert `i_rst` low asynchronously mid-period → all outputs 0 immediately. After release, the first rise produces no valid.
- **Macro off:** synchronous period 7, high 4 → `o_period=7`, `o_high=4`, and `o_valid` occurs 2 cycles earlier relative to `i_in` than in the macro-on build.
